// File: rtl/alu_ctrl_seq_pkg.sv
// -----------------------------------------------------------------------------
// alu_ctrl_pkg
// Shared types and constants for the ALU control sequencer: instruction
// opcodes, FSM states, ALU operation / branch-select encodings, the HALT
// instruction word and the decoded-control struct produced by instr_decoder.
// -----------------------------------------------------------------------------
package alu_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_ANDB = 3'b010,
    OP_XOR  = 3'b011,
    OP_SHL  = 3'b100,
    OP_SHR  = 3'b101,
    OP_BR   = 3'b110,
    OP_MEM  = 3'b111
  } opcode_e;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    EXEC,
    MEMW,
    WB,
    HALT
  } state_e;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_ANDB  = 2'b01;
  localparam logic [1:0] ALU_XOR   = 2'b10;
  localparam logic [1:0] ALU_SHIFT = 2'b11;

  localparam logic [1:0] BR_ZERO   = 2'b00;
  localparam logic [1:0] BR_SIGN   = 2'b01;
  localparam logic [1:0] BR_OVF    = 2'b10;
  localparam logic [1:0] BR_ALWAYS = 2'b11;

  localparam logic [8:0] HALT_INSTR = 9'h1FF;

  typedef struct packed {
    logic [1:0] alu_op;
    logic       sub;
    logic       branch;
    logic [1:0] branch_sel;
    logic       shift_left;
    logic [2:0] ra;
    logic [2:0] rb;
    logic [2:0] wa;
    logic       is_mem;
    logic       is_store;
    logic       is_br;
    logic       is_halt;
  } ctrl_t;

endpackage

// File: rtl/alu_ctrl_seq_instr_decoder.sv
// -----------------------------------------------------------------------------
// instr_decoder
// Purely combinational decode of a 9-bit instruction word into ALU controls,
// register-file addresses and instruction-class flags.
//   instr  in  9       instruction word (op=[8:6], rd=[5:3], rs=[2:0])
//   ctrl   out ctrl_t  decoded control bundle
// The all-ones word is HALT and wins over the MEM opcode it aliases.
// -----------------------------------------------------------------------------
module instr_decoder
  import alu_ctrl_pkg::*;
(
  input  logic [8:0] instr,
  output ctrl_t      ctrl
);

  opcode_e op;
  assign op = opcode_e'(instr[8:6]);

  always_comb begin
    // NOTE: give every combinational output a default before the case so that
    // no path leaves it unassigned and a latch is never inferred.
    ctrl = '0;
    if (instr == HALT_INSTR) begin
      ctrl.is_halt = 1'b1;
    end else begin
      case (op)
        OP_ADD, OP_SUB, OP_ANDB, OP_XOR, OP_SHL, OP_SHR: begin
          ctrl.ra = instr[5:3];
          ctrl.rb = instr[2:0];
          ctrl.wa = instr[5:3];
          unique case (op)
            OP_ADD:  ctrl.alu_op = ALU_ADD;
            OP_SUB:  begin ctrl.alu_op = ALU_ADD; ctrl.sub = 1'b1; end
            OP_ANDB: ctrl.alu_op = ALU_ANDB;
            OP_XOR:  ctrl.alu_op = ALU_XOR;
            OP_SHL:  begin ctrl.alu_op = ALU_SHIFT; ctrl.shift_left = 1'b1; end
            default: ctrl.alu_op = ALU_SHIFT;  // OP_SHR
          endcase
        end
        OP_BR: begin
          // Branch compares r1 - r2; the ALU reports the selected flag.
          ctrl.alu_op     = ALU_ADD;
          ctrl.sub        = 1'b1;
          ctrl.branch     = 1'b1;
          ctrl.branch_sel = instr[5:4];
          ctrl.ra         = 3'd1;
          ctrl.rb         = 3'd2;
          ctrl.is_br      = 1'b1;
        end
        default: begin  // OP_MEM
          // Address register feeds ALU in1; the data register is the store
          // source (rb) or the load destination (wa).
          ctrl.alu_op   = ALU_ADD;
          ctrl.is_mem   = 1'b1;
          ctrl.is_store = instr[5];
          ctrl.ra       = {1'b0, instr[1:0]};
          if (instr[5]) ctrl.rb = instr[4:2];
          else          ctrl.wa = instr[4:2];
        end
      endcase
    end
  end

endmodule

// File: rtl/alu_ctrl_seq.sv
// -----------------------------------------------------------------------------
// alu_ctrl_seq
// Multi-cycle control sequencer on the issuing side of the ALU interface.
// Owns the PC, fetches from a combinational instruction memory, drives ALU,
// register-file and memory strobes, and resolves branches from alu_result[0].
//   clk, rst_n        clock (rising) / asynchronous active-low reset
//   start             begin at pc=0 (accepted in IDLE or HALT only)
//   instr_in          instruction at pc
//   pc                fetch address (wraps modulo 2^PC_W)
//   alu_result        ALU output; bit0 is the branch flag
//   alu_op/sub/branch/branch_sel/shift_left   ALU controls (EXEC only)
//   rf_ra/rf_rb/rf_wa register addresses; rf_we/rf_wsel write strobe/select
//   mem_req/mem_we/mem_ready                  memory handshake
//   done              high in HALT
//   instr_count       retired-instruction count
// Optional: define INSTR_CNT_EN for a saturating retired-instruction counter;
// otherwise instr_count is tied to zero.
// All control outputs are registered: each transition loads the values the
// next state needs.
// -----------------------------------------------------------------------------
module alu_ctrl_seq
  import alu_ctrl_pkg::*;
#(
  parameter int PC_W  = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [8:0]       instr_in,
  output logic [PC_W-1:0]  pc,
  input  logic [7:0]       alu_result,
  output logic [1:0]       alu_op,
  output logic             alu_sub,
  output logic             alu_branch,
  output logic [1:0]       alu_branch_sel,
  output logic             alu_shift_left,
  output logic [2:0]       rf_ra,
  output logic [2:0]       rf_rb,
  output logic [2:0]       rf_wa,
  output logic             rf_we,
  output logic             rf_wsel,
  output logic             mem_req,
  output logic             mem_we,
  input  logic             mem_ready,
  output logic             done,
  output logic [CNT_W-1:0] instr_count
);

  state_e          state;
  ctrl_t           dec;
  logic            is_br_q, is_mem_q, is_store_q, is_halt_q;
  logic [3:0]      br_off_q;
  logic [PC_W-1:0] pc_inc, pc_br;
  logic            br_taken, start_acc;
  logic            unused_alu_bits;

  // Decode the word being fetched so EXEC outputs can be registered at FETCH.
  instr_decoder u_dec (
    .instr (instr_in),
    .ctrl  (dec)
  );

  assign pc_inc    = pc + PC_W'(1);
  assign pc_br     = pc + {{(PC_W-4){br_off_q[3]}}, br_off_q};
  // alu_branch_sel holds the decoded branch select while in EXEC.
  assign br_taken  = alu_result[0] || (alu_branch_sel == BR_ALWAYS);
  assign start_acc = start && (state == IDLE || state == HALT);
  assign unused_alu_bits = ^alu_result[7:1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      pc             <= '0;
      is_br_q        <= 1'b0;
      is_mem_q       <= 1'b0;
      is_store_q     <= 1'b0;
      is_halt_q      <= 1'b0;
      br_off_q       <= '0;
      alu_op         <= '0;
      alu_sub        <= 1'b0;
      alu_branch     <= 1'b0;
      alu_branch_sel <= '0;
      alu_shift_left <= 1'b0;
      rf_ra          <= '0;
      rf_rb          <= '0;
      rf_wa          <= '0;
      rf_we          <= 1'b0;
      rf_wsel        <= 1'b0;
      mem_req        <= 1'b0;
      mem_we         <= 1'b0;
      done           <= 1'b0;
    end else begin
      // NOTE: these non-blocking defaults are overridden by later non-blocking
      // assignments in the case below; the last one scheduled wins.
      alu_op         <= '0;
      alu_sub        <= 1'b0;
      alu_branch     <= 1'b0;
      alu_branch_sel <= '0;
      alu_shift_left <= 1'b0;
      rf_ra          <= '0;
      rf_rb          <= '0;
      rf_wa          <= '0;
      rf_we          <= 1'b0;
      rf_wsel        <= 1'b0;
      mem_req        <= 1'b0;
      mem_we         <= 1'b0;
      done           <= 1'b0;

      case (state)
        IDLE: begin
          if (start_acc) begin
            state <= FETCH;
            pc    <= '0;
          end
        end
        FETCH: begin
          state          <= EXEC;
          is_br_q        <= dec.is_br;
          is_mem_q       <= dec.is_mem;
          is_store_q     <= dec.is_store;
          is_halt_q      <= dec.is_halt;
          br_off_q       <= instr_in[3:0];
          alu_op         <= dec.alu_op;
          alu_sub        <= dec.sub;
          alu_branch     <= dec.branch;
          alu_branch_sel <= dec.branch_sel;
          alu_shift_left <= dec.shift_left;
          rf_ra          <= dec.ra;
          rf_rb          <= dec.rb;
          rf_wa          <= dec.wa;
        end
        EXEC: begin
          if (is_halt_q) begin
            state <= HALT;
            done  <= 1'b1;
          end else if (is_br_q) begin
            state <= FETCH;
            pc    <= br_taken ? pc_br : pc_inc;
          end else begin
            rf_ra <= rf_ra;
            rf_rb <= rf_rb;
            rf_wa <= rf_wa;
            if (is_mem_q) begin
              state   <= MEMW;
              mem_req <= 1'b1;
              mem_we  <= is_store_q;
            end else begin
              state <= WB;
              rf_we <= 1'b1;
            end
          end
        end
        MEMW: begin
          if (mem_ready && is_store_q) begin
            state <= FETCH;
            pc    <= pc_inc;
          end else begin
            rf_ra <= rf_ra;
            rf_rb <= rf_rb;
            rf_wa <= rf_wa;
            if (mem_ready) begin
              state   <= WB;
              rf_we   <= 1'b1;
              rf_wsel <= 1'b1;
            end else begin
              mem_req <= 1'b1;
              mem_we  <= mem_we;
            end
          end
        end
        WB: begin
          state <= FETCH;
          pc    <= pc_inc;
        end
        default: begin  // HALT
          if (start_acc) begin
            state <= FETCH;
            pc    <= '0;
          end else begin
            done <= 1'b1;
          end
        end
      endcase
    end
  end

`ifdef INSTR_CNT_EN
  logic retire;

  // Retirement points: WB exit, branch in EXEC, store completion, HALT entry.
  assign retire = (state == WB) ||
                  (state == EXEC && (is_br_q || is_halt_q)) ||
                  (state == MEMW && mem_ready && is_store_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         instr_count <= '0;
    else if (start_acc)                 instr_count <= '0;
    else if (retire && ~&instr_count)   instr_count <= instr_count + CNT_W'(1);
  end
`else
  assign instr_count = '0;
`endif

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_ctrl_seq
// Directed bench for alu_ctrl_seq: a table of single-instruction vectors
// (each reached by a run of ADD r0,r0 fillers) plus hand-written sequences for
// memory wait states, HALT/restart, the retired counter and async reset.
// -----------------------------------------------------------------------------
module tb_alu_ctrl_seq;
  import alu_ctrl_pkg::*;

  localparam int PC_W  = 8;
  localparam int CNT_W = 16;
`ifdef INSTR_CNT_EN
  localparam int CNT_ON = 1;
`else
  localparam int CNT_ON = 0;
`endif

  logic             clk = 1'b0;
  logic             rst_n, start, mem_ready;
  logic [8:0]       instr_in;
  logic [7:0]       alu_result;
  logic [PC_W-1:0]  pc;
  logic [1:0]       alu_op, alu_branch_sel;
  logic             alu_sub, alu_branch, alu_shift_left;
  logic [2:0]       rf_ra, rf_rb, rf_wa;
  logic             rf_we, rf_wsel, mem_req, mem_we, done;
  logic [CNT_W-1:0] instr_count;

  logic [8:0] imem [256];
  assign instr_in = imem[pc];

  always #5 clk = ~clk;

  alu_ctrl_seq #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .instr_in       (instr_in),
    .pc             (pc),
    .alu_result     (alu_result),
    .alu_op         (alu_op),
    .alu_sub        (alu_sub),
    .alu_branch     (alu_branch),
    .alu_branch_sel (alu_branch_sel),
    .alu_shift_left (alu_shift_left),
    .rf_ra          (rf_ra),
    .rf_rb          (rf_rb),
    .rf_wa          (rf_wa),
    .rf_we          (rf_we),
    .rf_wsel        (rf_wsel),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .mem_ready      (mem_ready),
    .done           (done),
    .instr_count    (instr_count)
  );

  typedef struct {
    string      name;
    logic [7:0] at_pc;
    logic [8:0] instr;
    logic [7:0] alu_res;
    logic [12:0] exp_ctrl;  // {alu_op, sub, branch, branch_sel, shift_left, ra, rb}
    logic       exp_wb;
    logic [2:0] exp_wa;
    logic [7:0] exp_pc;
  } vec_t;

  vec_t vecs [13];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [12:0] ctl(input logic [1:0] op, input logic sub, input logic br,
                                      input logic [1:0] bsel, input logic shl,
                                      input logic [2:0] ra, input logic [2:0] rb);
    return {op, sub, br, bsel, shl, ra, rb};
  endfunction

  function automatic logic [63:0] all_outs();
    return {pc, alu_op, alu_sub, alu_branch, alu_branch_sel, alu_shift_left,
            rf_ra, rf_rb, rf_wa, rf_we, rf_wsel, mem_req, mem_we, done, instr_count};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    start      = 1'b0;
    mem_ready  = 1'b0;
    alu_result = 8'h00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic fill_nop();
    for (int i = 0; i < 256; i++) imem[i] = 9'h000;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Each filler ADD takes 3 cycles, so EXEC of the target is 3*pc+1 edges on.
  task automatic run_vec(input vec_t v);
    do_reset();
    fill_nop();
    imem[v.at_pc] = v.instr;
    alu_result    = v.alu_res;
    pulse_start();
    repeat (3 * int'(v.at_pc) + 1) tick();
    check({v.name, "_exec_pc"}, pc, v.at_pc);
    check({v.name, "_exec"},
          {alu_op, alu_sub, alu_branch, alu_branch_sel, alu_shift_left, rf_ra, rf_rb, rf_we, mem_req},
          {v.exp_ctrl, 2'b00});
    tick();
    if (v.exp_wb) begin
      check({v.name, "_wb"}, {rf_we, rf_wsel, rf_wa, rf_ra, alu_op, alu_sub},
            {1'b1, 1'b0, v.exp_wa, v.exp_ctrl[5:3], 2'b00, 1'b0});
      tick();
    end else begin
      check({v.name, "_after_exec"}, {alu_branch, alu_branch_sel, alu_sub, rf_we, rf_ra}, '0);
    end
    check({v.name, "_next_pc"}, pc, v.exp_pc);
  endtask

  initial begin
    int n;
    vecs[0]  = '{"add",      8'd0,   9'b000_011_101, 8'h00, ctl(ALU_ADD,   0, 0, BR_ZERO,   0, 3'd3, 3'd5), 1'b1, 3'd3, 8'd1};
    vecs[1]  = '{"sub",      8'd0,   9'b001_001_010, 8'h00, ctl(ALU_ADD,   1, 0, BR_ZERO,   0, 3'd1, 3'd2), 1'b1, 3'd1, 8'd1};
    vecs[2]  = '{"andb",     8'd1,   9'b010_111_110, 8'h00, ctl(ALU_ANDB,  0, 0, BR_ZERO,   0, 3'd7, 3'd6), 1'b1, 3'd7, 8'd2};
    vecs[3]  = '{"xor",      8'd0,   9'b011_100_000, 8'h00, ctl(ALU_XOR,   0, 0, BR_ZERO,   0, 3'd4, 3'd0), 1'b1, 3'd4, 8'd1};
    vecs[4]  = '{"shl",      8'd2,   9'b100_010_011, 8'h00, ctl(ALU_SHIFT, 0, 0, BR_ZERO,   1, 3'd2, 3'd3), 1'b1, 3'd2, 8'd3};
    vecs[5]  = '{"shr",      8'd0,   9'b101_101_001, 8'h00, ctl(ALU_SHIFT, 0, 0, BR_ZERO,   0, 3'd5, 3'd1), 1'b1, 3'd5, 8'd1};
    vecs[6]  = '{"br_taken", 8'd10,  9'b110_00_1101, 8'h01, ctl(ALU_ADD,   1, 1, BR_ZERO,   0, 3'd1, 3'd2), 1'b0, 3'd0, 8'd7};
    vecs[7]  = '{"br_not",   8'd10,  9'b110_00_1101, 8'h00, ctl(ALU_ADD,   1, 1, BR_ZERO,   0, 3'd1, 3'd2), 1'b0, 3'd0, 8'd11};
    vecs[8]  = '{"br_always",8'd255, 9'b110_11_0001, 8'h00, ctl(ALU_ADD,   1, 1, BR_ALWAYS, 0, 3'd1, 3'd2), 1'b0, 3'd0, 8'd0};
    vecs[9]  = '{"br_self",  8'd4,   9'b110_01_0000, 8'hFF, ctl(ALU_ADD,   1, 1, BR_SIGN,   0, 3'd1, 3'd2), 1'b0, 3'd0, 8'd4};
    vecs[10] = '{"br_wrap",  8'd0,   9'b110_10_1111, 8'h03, ctl(ALU_ADD,   1, 1, BR_OVF,    0, 3'd1, 3'd2), 1'b0, 3'd0, 8'd255};
    vecs[11] = '{"br_ovf_nt",8'd3,   9'b110_10_0101, 8'hFE, ctl(ALU_ADD,   1, 1, BR_OVF,    0, 3'd1, 3'd2), 1'b0, 3'd0, 8'd4};
    vecs[12] = '{"add_wrap", 8'd255, 9'b000_001_001, 8'h00, ctl(ALU_ADD,   0, 0, BR_ZERO,   0, 3'd1, 3'd1), 1'b1, 3'd1, 8'd0};

    // Reset state and idle without start.
    fill_nop();
    do_reset();
    #1;
    check("reset_outs", all_outs(), '0);
    repeat (3) tick();
    check("idle_no_start", all_outs(), '0);

    for (int i = 0; i < 13; i++) run_vec(vecs[i]);

    // Load with three wait cycles, store with none, then HALT.
    do_reset();
    fill_nop();
    imem[0] = 9'b111_0_101_10;  // load r5 <- [r2]
    imem[1] = 9'b111_1_011_01;  // store r3 -> [r1]
    imem[2] = HALT_INSTR;
    pulse_start();
    tick();
    check("ld_exec", {rf_ra, rf_wa, mem_req}, {3'd2, 3'd5, 1'b0});
    tick();
    check("ld_memw", {mem_req, mem_we, rf_we, rf_ra}, {1'b1, 1'b0, 1'b0, 3'd2});
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (!mem_req) break;
      n++;
      mem_ready = (n >= 4);
      start     = (n == 2);   // must be ignored in MEMW
      tick();
    end
    mem_ready = 1'b0;
    start     = 1'b0;
    check("ld_req_cycles", n, 4);
    check("ld_wb", {rf_we, rf_wsel, rf_wa, mem_req}, {1'b1, 1'b1, 3'd5, 1'b0});
    tick();
    check("ld_next_pc", pc, 1);
    tick();
    check("st_exec", {rf_ra, rf_rb}, {3'd1, 3'd3});
    tick();
    check("st_memw", {mem_req, mem_we, rf_we}, {1'b1, 1'b1, 1'b0});
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    check("st_done", {pc, rf_we, mem_req, mem_we}, {8'd2, 1'b0, 1'b0, 1'b0});
    tick();
    tick();
    check("halt_entry", {done, pc}, {1'b1, 8'd2});
    repeat (3) tick();
    check("halt_frozen", {done, pc}, {1'b1, 8'd2});
    check("cnt_ldst_halt", instr_count, CNT_ON ? 3 : 0);
    pulse_start();
    check("restart", {done, pc, instr_count}, '0);

    // Five ALU ops then HALT: six retirements.
    do_reset();
    fill_nop();
    imem[5] = HALT_INSTR;
    pulse_start();
    for (int i = 0; i < 100; i++) begin
      if (done) break;
      tick();
    end
    check("halt_reached", {done, pc}, {1'b1, 8'd5});
    check("cnt_six", instr_count, CNT_ON ? 6 : 0);

    // Asynchronous reset in the middle of a memory wait.
    do_reset();
    fill_nop();
    imem[0] = 9'b111_0_101_10;
    pulse_start();
    tick();
    tick();
    check("pre_rst_memw", mem_req, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_outs", all_outs(), '0);
    do_reset();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
